pipe_decode: RTL and testbench

Registered, handshaked instruction-decode stage between fetch and execute of the pipelined core. Accepts one 32-bit instruction per cycle, decodes opcode/funct into the control bundle, and holds it in one output register with valid/ready flow control. Adds load-use interlock (one bubble), flush, illegal-opcode flagging and a saturating stall counter. Push/pop decoding is selectable.

---
 rtl/decode_pkg.sv | 54 +++++
 rtl/pipe_decode_if.sv | 40 ++++
 rtl/ctrl_decode.sv | 88 ++++++++
 rtl/pipe_decode.sv | 114 +++++++++++
 tb/tb_pipe_decode.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared encodings and the control bundle for the decode stage.
// Opcodes, ALU/jump/stack codes, FSM states and the rt-usage helper.
package decode_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_JR   = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_PUSH = 6'b110000;
  localparam logic [5:0] OP_POP  = 6'b110001;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_PUSH = 4'b1100;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_IMM  = 2'b01;
  localparam logic [1:0] JMP_REG  = 2'b10;

  localparam logic [1:0] STK_NONE = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b10;
  localparam logic [1:0] STK_POP  = 2'b11;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       need_zext;
    logic       alu_src;
    logic       branch;
    logic       link;
    logic [3:0] alu_op;
    logic [1:0] jump;
    logic [1:0] stack_op;
  } ctrl_t;

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  // Only these formats read rt as a source operand.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_R) || (opcode == OP_BEQ) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/pipe_decode_if.sv
// Fetch-side and execute-side handshake plus the decoded control outputs.
// master drives the instruction stream and consumes the bundle; slave is the stage.
interface pipe_decode_if #(
  parameter int CNT_W = 16
);
  logic             InValid;
  logic             InReady;
  logic [31:0]      InInstr;
  logic             Flush;
  logic             OutValid;
  logic             OutReady;
  logic [31:0]      OutInstr;
  logic [4:0]       WriteReg;
  logic             RegDst;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             MemToReg;
  logic             NeedZEXT;
  logic             ALUsrc;
  logic             Branch;
  logic             Link;
  logic [3:0]       ALUop;
  logic [1:0]       Jump;
  logic [1:0]       StackOp;
  logic             Illegal;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output InValid, InInstr, Flush, OutReady,
    input  InReady, OutValid, OutInstr, WriteReg, RegDst, RegWrite, MemRead, MemWrite,
           MemToReg, NeedZEXT, ALUsrc, Branch, Link, ALUop, Jump, StackOp, Illegal, StallCount
  );

  modport slave (
    input  InValid, InInstr, Flush, OutReady,
    output InReady, OutValid, OutInstr, WriteReg, RegDst, RegWrite, MemRead, MemWrite,
           MemToReg, NeedZEXT, ALUsrc, Branch, Link, ALUop, Jump, StackOp, Illegal, StallCount
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decode into the control bundle; zero latency.
// Undecodable opcodes (and push/pop when the stack is disabled) give all-zero controls and illegal.
module ctrl_decode
  import decode_pkg::*;
#(
  parameter bit STACK_EN = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [5:0] opcode;
  logic       unused_bits;

  assign opcode      = instr[31:26];
  assign unused_bits = ^instr[25:4];

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = instr[3:0];
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_ANDI, OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.need_zext = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OP_J, OP_JAL: begin
        ctrl.alu_src = 1'b1;
        ctrl.jump    = JMP_IMM;
        ctrl.link    = (opcode == OP_JAL);
      end
      OP_JR: begin
        ctrl.alu_src = 1'b1;
        ctrl.jump    = JMP_REG;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_PUSH: begin
        if (STACK_EN) begin
          ctrl.alu_src  = 1'b1;
          ctrl.alu_op   = ALU_PUSH;
          ctrl.stack_op = STK_PUSH;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_POP: begin
        if (STACK_EN) begin
          ctrl.reg_dst    = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.stack_op   = STK_POP;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_decode.sv
// Registered decode stage: one output register, 1-cycle latency, full throughput.
// Stalls on output backpressure or load-use hazard (one bubble); flush kills held and incoming.
module pipe_decode
  import decode_pkg::*;
#(
  parameter bit STACK_EN  = 1'b1,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic          Clk,
  input logic          Rst_n,
  pipe_decode_if.slave bus
);

  ctrl_t            dec_ctrl;
  ctrl_t            hold_ctrl;
  logic             dec_illegal;
  logic             hold_illegal;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       dec_wreg;
  logic [4:0]       hold_wreg;
  logic [31:0]      hold_instr;
  logic             out_vld;
  logic             haz;
  logic             in_xfer;
  logic             out_xfer;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] stall_cnt;

  ctrl_decode #(.STACK_EN(STACK_EN)) u_ctrl_decode (
    .instr   (bus.InInstr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign rs       = bus.InInstr[25:21];
  assign rt       = bus.InInstr[20:16];
  assign dec_wreg = dec_ctrl.reg_dst ? bus.InInstr[15:11] : rt;

  // Held load whose destination is read by the incoming instruction; $0 never conflicts.
  assign haz = HAZARD_EN && out_vld && hold_ctrl.mem_to_reg && (hold_wreg != 5'd0) &&
               ((hold_wreg == rs) || (uses_rt(bus.InInstr[31:26]) && (hold_wreg == rt)));

  assign bus.InReady = !bus.Flush && !haz && (!out_vld || bus.OutReady);
  assign in_xfer     = bus.InValid && bus.InReady;
  assign out_xfer    = out_vld && bus.OutReady;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_vld      <= 1'b0;
      hold_instr   <= '0;
      hold_ctrl    <= '0;
      hold_illegal <= 1'b0;
      hold_wreg    <= '0;
    end else if (bus.Flush) begin
      out_vld <= 1'b0;
    end else if (in_xfer) begin
      out_vld      <= 1'b1;
      hold_instr   <= bus.InInstr;
      hold_ctrl    <= dec_ctrl;
      hold_illegal <= dec_illegal;
      hold_wreg    <= dec_wreg;
    end else if (out_xfer) begin
      out_vld <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (haz && bus.InValid && out_xfer) state_nxt = BUBBLE;
      BUBBLE:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (bus.Flush) state_nxt = RUN;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
    end else if (!bus.Flush && haz && bus.InValid && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.OutValid   = out_vld;
  assign bus.OutInstr   = hold_instr;
  assign bus.WriteReg   = hold_wreg;
  assign bus.RegDst     = hold_ctrl.reg_dst;
  assign bus.RegWrite   = hold_ctrl.reg_write;
  assign bus.MemRead    = hold_ctrl.mem_read;
  assign bus.MemWrite   = hold_ctrl.mem_write;
  assign bus.MemToReg   = hold_ctrl.mem_to_reg;
  assign bus.NeedZEXT   = hold_ctrl.need_zext;
  assign bus.ALUsrc     = hold_ctrl.alu_src;
  assign bus.Branch     = hold_ctrl.branch;
  assign bus.Link       = hold_ctrl.link;
  assign bus.ALUop      = hold_ctrl.alu_op;
  assign bus.Jump       = hold_ctrl.jump;
  assign bus.StackOp    = hold_ctrl.stack_op;
  assign bus.Illegal    = hold_illegal;
  assign bus.StallCount = stall_cnt;

endmodule

// File: tb/tb_pipe_decode.sv
// Scoreboarded bench for pipe_decode: default instance plus a stack-off, hazard-off instance.
module tb_pipe_decode;
  import decode_pkg::*;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  pipe_decode_if #(.CNT_W(16)) a ();
  pipe_decode_if #(.CNT_W(16)) b ();

  pipe_decode #(.STACK_EN(1'b1), .HAZARD_EN(1'b1), .CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .bus(a)
  );
  pipe_decode #(.STACK_EN(1'b0), .HAZARD_EN(1'b0), .CNT_W(16)) dut_nh (
    .Clk(Clk), .Rst_n(Rst_n), .bus(b)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [54:0] sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  // Bundle = {instr, WriteReg, RegDst..Link (9), ALUop, Jump, StackOp, Illegal}
  function automatic logic [54:0] exp_bundle(input logic [31:0] ins, input bit stk);
    logic [16:0] c;
    logic        ill;
    logic [4:0]  wr;
    c   = '0;
    ill = 1'b0;
    case (ins[31:26])
      6'b000000: c = {9'b110000000, ins[3:0], 4'b0000};
      6'b001000: c = {9'b010000100, 4'b0010, 4'b0000};
      6'b001100: c = {9'b010001100, 4'b0000, 4'b0000};
      6'b001101: c = {9'b010001100, 4'b0001, 4'b0000};
      6'b000100: c = {9'b000000010, 4'b0011, 4'b0000};
      6'b000010: c = {9'b000000100, 4'b0000, 4'b0100};
      6'b000011: c = {9'b000000101, 4'b0000, 4'b0100};
      6'b000101: c = {9'b000000100, 4'b0000, 4'b1000};
      6'b100011: c = {9'b011010100, 4'b0010, 4'b0000};
      6'b101011: c = {9'b000100100, 4'b0010, 4'b0000};
      6'b110000: if (stk) c = {9'b000000100, 4'b1100, 4'b0010}; else ill = 1'b1;
      6'b110001: if (stk) c = {9'b110010100, 4'b0000, 4'b0011}; else ill = 1'b1;
      default:   ill = 1'b1;
    endcase
    wr = c[16] ? ins[15:11] : ins[20:16];
    return {ins, wr, c, ill};
  endfunction

  function automatic logic [54:0] obs_a();
    return {a.OutInstr, a.WriteReg, a.RegDst, a.RegWrite, a.MemRead, a.MemWrite, a.MemToReg,
            a.NeedZEXT, a.ALUsrc, a.Branch, a.Link, a.ALUop, a.Jump, a.StackOp, a.Illegal};
  endfunction

  function automatic logic [54:0] obs_b();
    return {b.OutInstr, b.WriteReg, b.RegDst, b.RegWrite, b.MemRead, b.MemWrite, b.MemToReg,
            b.NeedZEXT, b.ALUsrc, b.Branch, b.Link, b.ALUop, b.Jump, b.StackOp, b.Illegal};
  endfunction

  // Present one instruction until accepted; waited counts refused cycles.
  task automatic send(input logic [31:0] ins, output int waited);
    bit done;
    done   = 1'b0;
    waited = 0;
    a.InValid = 1'b1;
    a.InInstr = ins;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge Clk);
      if (a.InReady) begin
        sb.push_back(exp_bundle(ins, 1'b1));
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge Clk);
      #1;
    end
    a.InValid = 1'b0;
    if (!done) check("send_timeout", 64'(waited), 64'd0);
    else check("latency", {a.OutValid, a.OutInstr}, {1'b1, ins});
  endtask

  task automatic b_step(input logic [31:0] ins, output logic rdy);
    b.InValid = 1'b1;
    b.InInstr = ins;
    @(negedge Clk);
    rdy = b.InReady;
    @(posedge Clk);
    #1;
    b.InValid = 1'b0;
  endtask

  initial begin
    logic [54:0] want;
    forever begin
      @(negedge Clk);
      if (Rst_n) begin
        if (a.Flush) begin
          sb.delete();
        end else if (a.OutValid && a.OutReady) begin
          if (sb.size() != 0) want = sb.pop_front();
          else want = '1;
          check("bundle", obs_a(), want);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] strm [6];
    logic [31:0] lw3, add1, ins;
    logic [54:0] bv;
    logic        rdy;
    int          w;

    lw3     = mk(6'b100011, 5'd2, 5'd3, 5'd0, 6'd4);
    add1    = mk(6'b000000, 5'd3, 5'd5, 5'd4, 6'b100000);
    strm[0] = mk(6'b001000, 5'd2, 5'd1, 5'd0, 6'd5);
    strm[1] = mk(6'b001101, 5'd7, 5'd6, 5'd0, 6'd15);
    strm[2] = mk(6'b101011, 5'd2, 5'd1, 5'd0, 6'd8);
    strm[3] = mk(6'b000100, 5'd1, 5'd2, 5'd0, 6'd3);
    strm[4] = mk(6'b000011, 5'd0, 5'd0, 5'd1, 6'd0);
    strm[5] = lw3;

    Rst_n = 1'b0;
    a.InValid = 1'b0; a.InInstr = '0; a.Flush = 1'b0; a.OutReady = 1'b1;
    b.InValid = 1'b0; b.InInstr = '0; b.Flush = 1'b0; b.OutReady = 1'b1;

    @(negedge Clk);
    check("rst_bundle", obs_a(), 55'd0);
    check("rst_vld", a.OutValid, 1'b0);
    check("rst_cnt", a.StallCount, 16'd0);
    check("rst_fsm", dut.state, RUN);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(strm[i], w);
      check("stream_wait", 64'(w), 64'd0);
      if (i == 1) check("ori_ctl", {a.NeedZEXT, a.ALUop}, 5'b1_0001);
      if (i == 4) check("jal_ctl", {a.Jump, a.Link}, 3'b01_1);
    end
    check("stream_cnt", a.StallCount, 16'd0);

    // lw $3 held; dependent add presented
    a.InValid = 1'b1;
    a.InInstr = add1;
    @(negedge Clk);
    check("haz_rdy", a.InReady, 1'b0);
    @(posedge Clk);
    #1;
    check("bubble_vld", a.OutValid, 1'b0);
    send(add1, w);
    check("bubble_wait", 64'(w), 64'd0);
    check("haz_cnt", a.StallCount, 16'd1);

    send(mk(6'b100011, 5'd2, 5'd0, 5'd0, 6'd0), w);
    send(mk(6'b000000, 5'd0, 5'd0, 5'd4, 6'b100000), w);
    check("r0_nohaz", 64'(w), 64'd0);
    send(lw3, w);
    send(mk(6'b001000, 5'd2, 5'd3, 5'd0, 6'd1), w);
    check("rt_ignored", 64'(w), 64'd0);
    send(lw3, w);
    send(mk(6'b101011, 5'd2, 5'd3, 5'd0, 6'd0), w);
    check("sw_rt_haz", 64'(w), 64'd1);
    check("sw_cnt", a.StallCount, 16'd2);

    // backpressure
    send(strm[1], w);
    a.OutReady = 1'b0;
    a.InValid  = 1'b1;
    a.InInstr  = mk(6'b000101, 5'd31, 5'd0, 5'd0, 6'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("bp_rdy", a.InReady, 1'b0);
      check("bp_hold", obs_a(), exp_bundle(strm[1], 1'b1));
      @(posedge Clk);
      #1;
    end
    a.OutReady = 1'b1;
    send(mk(6'b000101, 5'd31, 5'd0, 5'd0, 6'd8), w);
    check("bp_resume", 64'(w), 64'd0);
    send(mk(6'b000010, 5'd0, 5'd0, 5'd2, 6'd0), w);
    check("bp_b2b", 64'(w), 64'd0);

    // flush with held and incoming instruction
    a.OutReady = 1'b0;
    a.Flush    = 1'b1;
    a.InValid  = 1'b1;
    a.InInstr  = strm[0];
    @(negedge Clk);
    check("flush_rdy", a.InReady, 1'b0);
    @(posedge Clk);
    #1;
    a.Flush   = 1'b0;
    a.InValid = 1'b0;
    check("flush_vld", a.OutValid, 1'b0);
    a.OutReady = 1'b1;

    // flush during the bubble
    send(lw3, w);
    a.InValid = 1'b1;
    a.InInstr = add1;
    @(negedge Clk);
    @(posedge Clk);
    #1;
    check("bub_fsm", dut.state, BUBBLE);
    a.Flush = 1'b1;
    @(negedge Clk);
    check("flb_rdy", a.InReady, 1'b0);
    @(posedge Clk);
    #1;
    a.Flush   = 1'b0;
    a.InValid = 1'b0;
    check("flb_fsm", dut.state, RUN);
    check("flb_vld", a.OutValid, 1'b0);
    check("flb_cnt", a.StallCount, 16'd3);

    // illegal and stack ops
    send(mk(6'b111111, 5'd1, 5'd2, 5'd3, 6'd0), w);
    bv = obs_a();
    check("ill_ctl", bv[17:0], 18'd1);
    send(mk(6'b110000, 5'd29, 5'd4, 5'd0, 6'd0), w);
    check("push_ctl", {a.StackOp, a.ALUop}, 6'b10_1100);
    send(mk(6'b110001, 5'd29, 5'd0, 5'd6, 6'd0), w);
    @(posedge Clk);
    #1;

    // hazard-off, stack-off instance
    b_step(lw3, rdy);
    check("nh_rdy_lw", rdy, 1'b1);
    b_step(add1, rdy);
    check("nh_rdy_add", rdy, 1'b1);
    check("nh_out", b.OutInstr, add1);
    check("nh_cnt", b.StallCount, 16'd0);
    ins = mk(6'b110000, 5'd29, 5'd4, 5'd0, 6'd0);
    b_step(ins, rdy);
    check("nh_push", obs_b(), exp_bundle(ins, 1'b0));

    @(posedge Clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'd0);

    // asynchronous reset with a held instruction
    a.OutReady = 1'b0;
    send(strm[0], w);
    #2;
    Rst_n = 1'b0;
    #1;
    check("arst_vld", a.OutValid, 1'b0);
    check("arst_bundle", obs_a(), 55'd0);
    sb.delete();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    a.OutReady = 1'b1;
    send(strm[3], w);
    @(posedge Clk);
    #1;
    check("end_drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
